led_sched: RTL and testbench

Four-channel LED pattern controller for the Qsys system. Provides an Avalon-MM slave through which software sets each LED to off, solid on, continuous blink, or a counted burst of blinks. One shared prescaler, derived from the board oscillator, produces a millisecond-class tick that paces all four channels. On burst completion the block raises a per-channel done flag and a maskable interrupt.

---
 rtl/led_sched.sv | 219 +++++++++++++++++++++
 tb/tb_led_sched.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_sched.sv
// led_sched: four-channel LED pattern controller with an Avalon-MM slave.
// A shared prescaler produces the channel tick. Each channel runs OFF/ON/BLINK/BURST
// and raises a sticky done flag when a counted burst completes.
module led_sched #(
  parameter int unsigned OSC_CLOCK = 27000000,
  parameter int unsigned TICK_HZ   = 1000
) (
  input  logic        in_clk,
  input  logic        reset_n,
  input  logic [3:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        irq,
  output logic [3:0]  led
);

  localparam int unsigned DIV     = OSC_CLOCK / TICK_HZ;
  localparam int unsigned PS_W    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned NCH     = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned PER_W   = 16;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

  // Channel state encoding matches the CFG mode field.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SOLID = 2'd1,
    ST_BLINK = 2'd2,
    ST_BURST = 2'd3
  } ch_state_t;

  // Software-visible registers
  logic                ctrl_en_q;
  logic [NCH-1:0]      irq_en_q;
  logic [NCH-1:0]      done_q;
  logic [1:0]          mode_q     [NCH];
  logic [CNT_W-1:0]    count_q    [NCH];
  logic [PER_W-1:0]    period_q   [NCH];

  // Channel engine state
  ch_state_t           state_q     [NCH];
  logic [PER_W-1:0]    hc_q        [NCH];
  logic [NCH-1:0]      phase_q;
  logic [CNT_W-1:0]    remaining_q [NCH];

  // Prescaler
  logic [PS_W-1:0]     ps_q;
  logic                tick_c;

  // Decode and helpers
  logic                wr_ctrl_c;
  logic                wr_status_c;
  logic                wr_irq_en_c;
  logic [NCH-1:0]      wr_cfg_c;
  logic [NCH-1:0]      wr_period_c;
  logic [PER_W-1:0]    eff_period_c [NCH];
  logic [NCH-1:0]      wrap_c;
  logic [NCH-1:0]      busy_c;
  logic [31:0]         rd_data_c;
  logic [CNT_W-1:0]    load_count_c;

  logic unused_wdata;
  assign unused_wdata = ^avs_writedata[31:16];

  // Write strobe decode per register
  always_comb begin
    wr_ctrl_c   = avs_write && (avs_address == 4'd0);
    wr_status_c = avs_write && (avs_address == 4'd1);
    wr_irq_en_c = avs_write && (avs_address == 4'd2);
    wr_cfg_c    = '0;
    wr_period_c = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_cfg_c[i]    = avs_write && (avs_address == 4'(4 + i));
      wr_period_c[i] = avs_write && (avs_address == 4'(8 + i));
    end
  end

  // Burst count of 0 is treated as a single blink
  always_comb begin
    load_count_c = avs_writedata[15:8];
    if (load_count_c == '0) begin
      load_count_c = CNT_W'(1);
    end
  end

  // Effective period, half-period wrap detect and busy flags
  always_comb begin
    wrap_c = '0;
    busy_c = '0;
    for (int i = 0; i < NCH; i++) begin
      eff_period_c[i] = (period_q[i] == '0) ? PER_W'(1) : period_q[i];
      wrap_c[i] = ({1'b0, hc_q[i]} + 17'd1) >= {1'b0, eff_period_c[i]};
      busy_c[i] = (state_q[i] == ST_BURST);
    end
  end

  // Tick fires on the last prescaler count while enabled
  assign tick_c = ctrl_en_q && (ps_q == PS_LAST);

  // Prescaler: free-running while enabled, held at 0 otherwise
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      ps_q <= '0;
    end else if (!ctrl_en_q) begin
      ps_q <= '0;
    end else if (ps_q == PS_LAST) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_q + PS_W'(1);
    end
  end

  // Configuration registers
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en_q <= 1'b0;
      irq_en_q  <= '0;
      for (int i = 0; i < NCH; i++) begin
        mode_q[i]   <= '0;
        count_q[i]  <= '0;
        period_q[i] <= '0;
      end
    end else begin
      if (wr_ctrl_c) begin
        ctrl_en_q <= avs_writedata[0];
      end
      if (wr_irq_en_c) begin
        irq_en_q <= avs_writedata[3:0];
      end
      for (int i = 0; i < NCH; i++) begin
        if (wr_cfg_c[i]) begin
          mode_q[i]  <= avs_writedata[1:0];
          count_q[i] <= avs_writedata[15:8];
        end
        if (wr_period_c[i]) begin
          period_q[i] <= avs_writedata[15:0];
        end
      end
    end
  end

  // Channel state machines and sticky done flags (a same-cycle set beats W1C)
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q  <= '0;
      phase_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i]     <= ST_IDLE;
        hc_q[i]        <= '0;
        remaining_q[i] <= '0;
      end
    end else begin
      if (wr_status_c) begin
        done_q <= done_q & ~avs_writedata[7:4];
      end
      for (int i = 0; i < NCH; i++) begin
        if (wr_cfg_c[i]) begin
          state_q[i]     <= ch_state_t'(avs_writedata[1:0]);
          hc_q[i]        <= '0;
          phase_q[i]     <= 1'b1;
          remaining_q[i] <= load_count_c;
        end else if (tick_c && (state_q[i] == ST_BLINK || state_q[i] == ST_BURST)) begin
          if (wrap_c[i]) begin
            hc_q[i]    <= '0;
            phase_q[i] <= ~phase_q[i];
            if (state_q[i] == ST_BURST && phase_q[i]) begin
              if (remaining_q[i] <= CNT_W'(1)) begin
                remaining_q[i] <= '0;
                state_q[i]     <= ST_IDLE;
                done_q[i]      <= 1'b1;
              end else begin
                remaining_q[i] <= remaining_q[i] - CNT_W'(1);
              end
            end
          end else begin
            hc_q[i] <= hc_q[i] + PER_W'(1);
          end
        end
      end
    end
  end

  // Register read mux
  always_comb begin
    rd_data_c = '0;
    case (avs_address)
      4'd0: rd_data_c[0] = ctrl_en_q;
      4'd1: rd_data_c[7:0] = {done_q, busy_c};
      4'd2: rd_data_c[3:0] = irq_en_q;
      4'd4, 4'd5, 4'd6, 4'd7:
        rd_data_c = {16'h0, count_q[avs_address[1:0]], 6'h0, mode_q[avs_address[1:0]]};
      4'd8, 4'd9, 4'd10, 4'd11:
        rd_data_c = {16'h0, period_q[avs_address[1:0]]};
      default: rd_data_c = '0;
    endcase
  end

  // Registered outputs: read data (held between reads), interrupt, LED drive
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= '0;
      irq          <= 1'b0;
      led          <= '0;
    end else begin
      if (avs_read) begin
        avs_readdata <= rd_data_c;
      end
      irq <= |(done_q & irq_en_q);
      for (int i = 0; i < NCH; i++) begin
        led[i] <= ctrl_en_q &&
                  ((state_q[i] == ST_SOLID) ||
                   ((state_q[i] == ST_BLINK || state_q[i] == ST_BURST) && phase_q[i]));
      end
    end
  end

endmodule

// File: tb/tb_led_sched.sv
// tb_led_sched: directed tests for led_sched with DIV = 100/10 = 10.
module tb_led_sched;

  logic        in_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        irq;
  logic [3:0]  led;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int en_edge = 0;

  led_sched #(.OSC_CLOCK(100), .TICK_HZ(10)) dut (
    .in_clk(in_clk),
    .reset_n(reset_n),
    .avs_address(avs_address),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_read(avs_read),
    .avs_readdata(avs_readdata),
    .irq(irq),
    .led(led)
  );

  always #5 in_clk = ~in_clk;

  // Edge counter used to line writes up with prescaler ticks
  always @(posedge in_clk) cyc <= cyc + 1;

  // All tasks start and end 1 time unit after a rising edge
  task automatic tick_clk(input int n);
    repeat (n) begin
      @(posedge in_clk);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    avs_address = a;
    avs_writedata = d;
    avs_write = 1'b1;
    @(posedge in_clk);
    #1;
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read = 1'b1;
    @(posedge in_clk);
    #1;
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  // Advance so the next edge is a prescaler tick edge
  task automatic align();
    while (((cyc + 1 - en_edge) % 10) != 0) tick_clk(1);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    total++;
    if (led !== 4'h0) begin bad++; $display("FAIL reset_led: got %h want 0", led); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    total++;
    if (avs_readdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", avs_readdata); end
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL reset_reg%0d: got %h want 0", a, d); end
    end
  endtask

  task automatic test_on_enable();
    logic [31:0] d;
    wr(4'd0, 32'h1);
    en_edge = cyc;
    wr(4'd4, 32'h1);
    total++;
    if (led[0] !== 1'b0) begin bad++; $display("FAIL on_early: got %b want 0", led[0]); end
    tick_clk(1);
    total++;
    if (led[0] !== 1'b1) begin bad++; $display("FAIL on_led: got %b want 1", led[0]); end
    wr(4'd0, 32'h0);
    tick_clk(1);
    total++;
    if (led !== 4'h0) begin bad++; $display("FAIL disable_led: got %h want 0", led); end
    tick_clk(30);
    total++;
    if (led !== 4'h0) begin bad++; $display("FAIL disable_hold: got %h want 0", led); end
    wr(4'd0, 32'h1);
    en_edge = cyc;
    tick_clk(1);
    total++;
    if (led[0] !== 1'b1) begin bad++; $display("FAIL reenable_led: got %b want 1", led[0]); end
    rd(4'd4, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL ch0_cfg_read: got %h want 1", d); end
  endtask

  task automatic test_blink();
    int t[12];
    int n = 0;
    logic prev;
    wr(4'd9, 32'd3);
    wr(4'd5, 32'h2);
    prev = led[1];
    for (int k = 0; k < 600 && n < 12; k++) begin
      tick_clk(1);
      if (led[1] !== prev) begin
        t[n] = cyc;
        n++;
        prev = led[1];
      end
    end
    total++;
    if (n < 12) begin
      bad++;
      $display("FAIL blink_edges: got %0d want 12", n);
    end else begin
      total++;
      if ((t[1] - t[0]) < 21 || (t[1] - t[0]) > 30) begin
        bad++; $display("FAIL blink_first: got %0d want 21..30", t[1] - t[0]);
      end
      for (int i = 2; i < 12; i++) begin
        total++;
        if ((t[i] - t[i-1]) != 30) begin
          bad++; $display("FAIL blink_half%0d: got %0d want 30", i, t[i] - t[i-1]);
        end
      end
    end
    wr(4'd5, 32'h0);
    tick_clk(1);
    total++;
    if (led[1] !== 1'b0) begin bad++; $display("FAIL blink_off: got %b want 0", led[1]); end
  endtask

  task automatic test_burst_irq();
    logic [31:0] d;
    int mism = 0;
    logic exp_led;
    wr(4'd2, 32'h4);
    wr(4'd10, 32'd1);
    align();
    wr(4'd6, 32'h0203);
    for (int k = 1; k <= 60; k++) begin
      if (k == 5) begin avs_address = 4'd1; avs_read = 1'b1; end
      tick_clk(1);
      if (k == 5) begin
        avs_read = 1'b0;
        total++;
        if (avs_readdata !== 32'h4) begin bad++; $display("FAIL burst_busy: got %h want 4", avs_readdata); end
      end
      exp_led = (k >= 1 && k <= 10) || (k >= 21 && k <= 30);
      if (led[2] !== exp_led) mism++;
    end
    total++;
    if (mism != 0) begin bad++; $display("FAIL burst_pattern: got %0d wrong cycles want 0", mism); end
    rd(4'd1, d);
    total++;
    if (d !== 32'h40) begin bad++; $display("FAIL burst_status: got %h want 40", d); end
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL burst_irq: got %b want 1", irq); end
    wr(4'd1, 32'h40);
    tick_clk(1);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear: got %b want 0", irq); end
    rd(4'd1, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL status_clear: got %h want 0", d); end
  endtask

  task automatic test_boundary();
    logic [31:0] d;
    int mism = 0;
    wr(4'd11, 32'd0);
    align();
    wr(4'd7, 32'h0003);
    for (int k = 1; k <= 12; k++) begin
      if (k == 10) begin avs_address = 4'd1; avs_writedata = 32'h80; avs_write = 1'b1; end
      tick_clk(1);
      if (k == 10) avs_write = 1'b0;
      if (led[3] !== (k <= 10)) mism++;
    end
    total++;
    if (mism != 0) begin bad++; $display("FAIL single_pulse: got %0d wrong cycles want 0", mism); end
    rd(4'd1, d);
    total++;
    if (d !== 32'h80) begin bad++; $display("FAIL w1c_race: got %h want 80", d); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_masked: got %b want 0", irq); end
    wr(4'd1, 32'h80);
    rd(4'd1, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL ch3_clear: got %h want 0", d); end
  endtask

  task automatic test_restart();
    logic [31:0] d;
    int mism = 0;
    int rises = 0;
    logic prev_irq;
    logic exp_led;
    align();
    wr(4'd6, 32'h0503);
    prev_irq = irq;
    for (int k = 1; k <= 100; k++) begin
      if (k == 40) begin avs_address = 4'd6; avs_writedata = 32'h0203; avs_write = 1'b1; end
      tick_clk(1);
      if (k == 40) avs_write = 1'b0;
      exp_led = (k >= 1 && k <= 10) || (k >= 21 && k <= 30) ||
                (k >= 41 && k <= 50) || (k >= 61 && k <= 70);
      if (led[2] !== exp_led) mism++;
      if (irq && !prev_irq) rises++;
      prev_irq = irq;
    end
    total++;
    if (mism != 0) begin bad++; $display("FAIL restart_pattern: got %0d wrong cycles want 0", mism); end
    total++;
    if (rises != 1) begin bad++; $display("FAIL restart_done_once: got %0d want 1", rises); end
    rd(4'd1, d);
    total++;
    if (d !== 32'h40) begin bad++; $display("FAIL restart_status: got %h want 40", d); end
  endtask

  task automatic test_reset_midblink();
    logic [31:0] d;
    wr(4'd9, 32'd3);
    wr(4'd5, 32'h2);
    tick_clk(45);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
    reset_n = 1'b0;
    #1;
    total++;
    if (led !== 4'h0) begin bad++; $display("FAIL midreset_led: got %h want 0", led); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL midreset_irq: got %b want 0", irq); end
    @(posedge in_clk);
    #1;
    tick_clk(1);
    reset_n = 1'b1;
    tick_clk(1);
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL postreset_reg%0d: got %h want 0", a, d); end
    end
    total++;
    if (led !== 4'h0) begin bad++; $display("FAIL postreset_led: got %h want 0", led); end
  endtask

  initial begin
    tick_clk(2);
    reset_n = 1'b1;
    tick_clk(1);
    test_reset();
    test_on_enable();
    test_blink();
    test_burst_irq();
    test_boundary();
    test_restart();
    test_reset_midblink();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
